// File: rtl/alu_reservation_station.sv
// Reservation station in front of the integer ALU. It holds dispatched ops until their
// operands arrive on the CDB, then issues the lowest ready entry, one per cycle.

`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

module alu_reservation_station #(
    parameter int RS_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        disp_valid,
    input  logic [3:0]                  disp_op,
    input  logic [31:0]                 disp_vj,
    input  logic [31:0]                 disp_vk,
    input  logic [`ROB_ENTRY_WIDTH-1:0] disp_qj,
    input  logic [`ROB_ENTRY_WIDTH-1:0] disp_qk,
    input  logic                        disp_qj_pend,
    input  logic                        disp_qk_pend,
    input  logic [`ROB_ENTRY_WIDTH-1:0] disp_dest,
    output logic                        rs_full,
    output logic [3:0]                  rs_count,
    input  logic                        cdb_valid,
    input  logic [`ROB_ENTRY_WIDTH-1:0] cdb_tag,
    input  logic [31:0]                 cdb_data,
    output logic [3:0]                  ALUOp,
    output logic [31:0]                 ALUSrcA,
    output logic [31:0]                 ALUSrcB,
    output logic [`ROB_ENTRY_WIDTH-1:0] Dest
);

    localparam int W     = `ROB_ENTRY_WIDTH;
    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    typedef struct packed {
        logic [3:0]   op;
        logic [31:0]  vj;
        logic [31:0]  vk;
        logic [W-1:0] qj;
        logic [W-1:0] qk;
        logic [W-1:0] dest;
    } payload_t;

    logic [RS_DEPTH-1:0] valid_q;
    logic [RS_DEPTH-1:0] qj_pend_q;
    logic [RS_DEPTH-1:0] qk_pend_q;
    payload_t            entry_q [RS_DEPTH];
    logic [3:0]          count_q;

    logic [RS_DEPTH-1:0] ready;
    logic                issue_found;
    logic [IDX_W-1:0]    issue_idx;
    logic [IDX_W-1:0]    free_idx;
    logic                accept;
    logic                do_issue;
    logic                disp_j_hit;
    logic                disp_k_hit;

    assign ready   = valid_q & ~qj_pend_q & ~qk_pend_q;
    assign rs_full = &valid_q;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        free_idx    = '0;
        // Scan downwards so the lowest matching index is the last one written.
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign accept   = disp_valid && !rs_full && (disp_op != 4'd0) && !flush;
    assign do_issue = issue_found && !flush;

    // A broadcast on the dispatch edge must not be lost for the incoming operands.
    assign disp_j_hit = disp_qj_pend && cdb_valid && (cdb_tag == disp_qj);
    assign disp_k_hit = disp_qk_pend && cdb_valid && (cdb_tag == disp_qk);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            qj_pend_q <= '0;
            qk_pend_q <= '0;
            count_q   <= '0;
            ALUOp     <= '0;
            ALUSrcA   <= '0;
            ALUSrcB   <= '0;
            Dest      <= '0;
        end else if (flush) begin
            valid_q   <= '0;
            qj_pend_q <= '0;
            qk_pend_q <= '0;
            count_q   <= '0;
            ALUOp     <= '0;
            ALUSrcA   <= '0;
            ALUSrcB   <= '0;
            Dest      <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (do_issue && issue_idx == IDX_W'(i)) begin
                    valid_q[i] <= 1'b0;
                end else if (accept && free_idx == IDX_W'(i)) begin
                    valid_q[i]   <= 1'b1;
                    qj_pend_q[i] <= disp_qj_pend && !disp_j_hit;
                    qk_pend_q[i] <= disp_qk_pend && !disp_k_hit;
                end else if (valid_q[i] && cdb_valid) begin
                    if (qj_pend_q[i] && entry_q[i].qj == cdb_tag) qj_pend_q[i] <= 1'b0;
                    if (qk_pend_q[i] && entry_q[i].qk == cdb_tag) qk_pend_q[i] <= 1'b0;
                end
            end

            if (do_issue) begin
                ALUOp   <= entry_q[issue_idx].op;
                ALUSrcA <= entry_q[issue_idx].vj;
                ALUSrcB <= entry_q[issue_idx].vk;
                Dest    <= entry_q[issue_idx].dest;
            end else begin
                ALUOp   <= '0;
                ALUSrcA <= '0;
                ALUSrcB <= '0;
                Dest    <= '0;
            end

            case ({accept, do_issue})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: payload storage has no reset; it is only read while its valid/pending flags say so.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (accept && free_idx == IDX_W'(i)) begin
                entry_q[i].op   <= disp_op;
                entry_q[i].vj   <= disp_j_hit ? cdb_data : disp_vj;
                entry_q[i].vk   <= disp_k_hit ? cdb_data : disp_vk;
                entry_q[i].qj   <= disp_qj;
                entry_q[i].qk   <= disp_qk;
                entry_q[i].dest <= disp_dest;
            end else if (valid_q[i] && cdb_valid) begin
                if (qj_pend_q[i] && entry_q[i].qj == cdb_tag) entry_q[i].vj <= cdb_data;
                if (qk_pend_q[i] && entry_q[i].qk == cdb_tag) entry_q[i].vk <= cdb_data;
            end
        end
    end

    assign rs_count = count_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed scenarios followed by random traffic,
// all compared against a slot-level behavioural model of the station.

`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

module tb_alu_reservation_station;

    localparam int RS_DEPTH = 4;
    localparam int W        = `ROB_ENTRY_WIDTH;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush, disp_valid, disp_qj_pend, disp_qk_pend, cdb_valid;
    logic [3:0]    disp_op;
    logic [31:0]   disp_vj, disp_vk, cdb_data;
    logic [W-1:0]  disp_qj, disp_qk, disp_dest, cdb_tag;
    logic          rs_full;
    logic [3:0]    rs_count, ALUOp;
    logic [31:0]   ALUSrcA, ALUSrcB;
    logic [W-1:0]  Dest;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit           v;
        logic [3:0]   op;
        logic [31:0]  vj, vk;
        logic [W-1:0] qj, qk, dest;
        bit           pj, pk;
    } ent_t;

    ent_t         m [RS_DEPTH];
    logic [3:0]   exp_op;
    logic [31:0]  exp_a, exp_b;
    logic [W-1:0] exp_dest;

    alu_reservation_station #(.RS_DEPTH(RS_DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_qj_pend(disp_qj_pend), .disp_qk_pend(disp_qk_pend),
        .disp_dest(disp_dest),
        .rs_full(rs_full), .rs_count(rs_count),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .Dest(Dest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < RS_DEPTH; i++) m[i].v = 1'b0;
        exp_op = '0; exp_a = '0; exp_b = '0; exp_dest = '0;
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < RS_DEPTH; i++) if (m[i].v) c++;
        return c;
    endfunction

    // One rising edge of the station, evaluated from the pre-edge entries and the current inputs.
    task automatic model_edge();
        ent_t nxt [RS_DEPTH];
        int   iss = -1;
        int   fre = -1;
        if (rst || flush) begin
            model_clear();
            return;
        end
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (iss < 0 && m[i].v && !m[i].pj && !m[i].pk) iss = i;
            if (fre < 0 && !m[i].v) fre = i;
        end
        nxt = m;
        if (iss >= 0) begin
            exp_op = m[iss].op; exp_a = m[iss].vj; exp_b = m[iss].vk; exp_dest = m[iss].dest;
            nxt[iss].v = 1'b0;
        end else begin
            exp_op = '0; exp_a = '0; exp_b = '0; exp_dest = '0;
        end
        if (cdb_valid) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (nxt[i].v && nxt[i].pj && nxt[i].qj == cdb_tag) begin nxt[i].vj = cdb_data; nxt[i].pj = 1'b0; end
                if (nxt[i].v && nxt[i].pk && nxt[i].qk == cdb_tag) begin nxt[i].vk = cdb_data; nxt[i].pk = 1'b0; end
            end
        end
        if (disp_valid && fre >= 0 && disp_op != 4'd0) begin
            nxt[fre].v    = 1'b1;
            nxt[fre].op   = disp_op;
            nxt[fre].qj   = disp_qj;
            nxt[fre].qk   = disp_qk;
            nxt[fre].dest = disp_dest;
            nxt[fre].pj   = disp_qj_pend;
            nxt[fre].pk   = disp_qk_pend;
            nxt[fre].vj   = disp_vj;
            nxt[fre].vk   = disp_vk;
            if (cdb_valid && disp_qj_pend && disp_qj == cdb_tag) begin nxt[fre].vj = cdb_data; nxt[fre].pj = 1'b0; end
            if (cdb_valid && disp_qk_pend && disp_qk == cdb_tag) begin nxt[fre].vk = cdb_data; nxt[fre].pk = 1'b0; end
        end
        m = nxt;
    endtask

    task automatic compare_all(input string tag);
        int c = model_count();
        check({tag, ".count"}, 32'(rs_count), 32'(c));
        check({tag, ".full"},  32'(rs_full),  32'(c == RS_DEPTH));
        check({tag, ".op"},    32'(ALUOp),    32'(exp_op));
        check({tag, ".a"},     ALUSrcA,       exp_a);
        check({tag, ".b"},     ALUSrcB,       exp_b);
        check({tag, ".dest"},  32'(Dest),     32'(exp_dest));
    endtask

    task automatic idle();
        flush = 0; disp_valid = 0; disp_op = '0; disp_vj = '0; disp_vk = '0;
        disp_qj = '0; disp_qk = '0; disp_qj_pend = 0; disp_qk_pend = 0; disp_dest = '0;
        cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [W-1:0] qj, input logic pj, input logic [W-1:0] qk,
                        input logic pk, input logic [W-1:0] dest);
        disp_valid = 1; disp_op = op; disp_vj = vj; disp_vk = vk;
        disp_qj = qj; disp_qj_pend = pj; disp_qk = qk; disp_qk_pend = pk; disp_dest = dest;
    endtask

    task automatic cdb(input logic [W-1:0] tag, input logic [31:0] data);
        cdb_valid = 1; cdb_tag = tag; cdb_data = data;
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
        idle();
    endtask

    initial begin
        idle();
        model_clear();
        #1;
        check("reset.count", 32'(rs_count), 32'd0);
        check("reset.full",  32'(rs_full),  32'd0);
        check("reset.op",    32'(ALUOp),    32'd0);
        @(posedge clk); #1;
        rst = 0;

        // Ready dispatch, one-edge latency, then NOP.
        disp(OP_ADD, 32'd5, 32'd7, '0, 0, '0, 0, W'(3)); tick("ready.e0");
        check("ready.no_early_issue", 32'(ALUOp), 32'd0);
        tick("ready.e1");
        check("ready.op",  32'(ALUOp), 32'(OP_ADD));
        check("ready.a",   ALUSrcA, 32'd5);
        check("ready.b",   ALUSrcB, 32'd7);
        check("ready.dst", 32'(Dest), 32'd3);
        tick("ready.e2");
        check("ready.nop", 32'(ALUOp), 32'd0);

        // CDB wake-up two edges after dispatch.
        disp(OP_SUB, 32'hdead, 32'd1, W'(2), 1, '0, 0, W'(4)); tick("wake.d");
        tick("wake.w");
        cdb(W'(2), 32'h10); tick("wake.bcast");
        check("wake.not_same_edge", 32'(ALUOp), 32'd0);
        tick("wake.issue");
        check("wake.op", 32'(ALUOp), 32'(OP_SUB));
        check("wake.a",  ALUSrcA, 32'h10);
        check("wake.b",  ALUSrcB, 32'd1);

        // Same-edge bypass of a broadcast into a dispatch.
        disp(OP_ADD, 32'd9, 32'h0, '0, 0, W'(6), 1, W'(1)); cdb(W'(6), 32'hAB); tick("byp.d");
        tick("byp.issue");
        check("byp.b", ALUSrcB, 32'hAB);

        // Fill, drop when full, lowest-index priority.
        disp(OP_ADD, 32'd0, 32'd10, W'(7), 1, '0, 0, W'(10)); tick("full.d0");
        disp(OP_SUB, 32'd0, 32'd11, W'(5), 1, '0, 0, W'(11)); tick("full.d1");
        disp(OP_ADD, 32'd0, 32'd12, W'(7), 1, '0, 0, W'(12)); tick("full.d2");
        disp(OP_SUB, 32'd0, 32'd13, W'(5), 1, '0, 0, W'(13)); tick("full.d3");
        check("full.flag", 32'(rs_full), 32'd1);
        disp(OP_ADD, 32'd1, 32'd1, '0, 0, '0, 0, W'(14)); cdb(W'(5), 32'h55); tick("full.drop");
        check("full.count4", 32'(rs_count), 32'd4);
        tick("full.iss1");
        check("full.dest1", 32'(Dest), 32'd11);
        check("full.count3", 32'(rs_count), 32'd3);
        tick("full.iss3");
        check("full.dest3", 32'(Dest), 32'd13);
        check("full.a3", ALUSrcA, 32'h55);
        check("full.count2", 32'(rs_count), 32'd2);

        // Flush overrides dispatch, capture and issue.
        disp(OP_ADD, 32'd0, 32'd2, W'(7), 1, '0, 0, W'(15)); tick("flush.pre");
        check("flush.count3", 32'(rs_count), 32'd3);
        flush = 1; disp(OP_ADD, 32'd3, 32'd4, '0, 0, '0, 0, W'(9)); cdb(W'(7), 32'h77); tick("flush.edge");
        check("flush.count", 32'(rs_count), 32'd0);
        check("flush.op", 32'(ALUOp), 32'd0);
        tick("flush.after1");
        tick("flush.after2");

        // Asynchronous reset between edges.
        disp(OP_ADD, 32'd1, 32'd2, '0, 0, '0, 0, W'(1)); tick("arst.d0");
        disp(OP_SUB, 32'd3, 32'd4, '0, 0, '0, 0, W'(2)); tick("arst.d1");
        check("arst.pre_op", 32'(ALUOp), 32'(OP_ADD));
        #2 rst = 1;
        #1;
        model_clear();
        check("arst.op",    32'(ALUOp),    32'd0);
        check("arst.a",     ALUSrcA,       32'd0);
        check("arst.count", 32'(rs_count), 32'd0);
        check("arst.full",  32'(rs_full),  32'd0);
        disp(OP_ADD, 32'd8, 32'd8, '0, 0, '0, 0, W'(5)); cdb(W'(0), 32'd1); tick("arst.held");
        #2 rst = 0;
        tick("arst.after1");
        tick("arst.after2");

        // Random traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            flush        = ($urandom_range(0, 39) == 0);
            disp_valid   = ($urandom_range(0, 3) != 0);
            disp_op      = 4'($urandom_range(0, 15));
            disp_vj      = $urandom;
            disp_vk      = $urandom;
            disp_qj      = W'($urandom_range(0, 7));
            disp_qk      = W'($urandom_range(0, 7));
            disp_qj_pend = $urandom_range(0, 1) != 0;
            disp_qk_pend = $urandom_range(0, 1) != 0;
            disp_dest    = W'($urandom);
            cdb_valid    = $urandom_range(0, 1) != 0;
            cdb_tag      = W'($urandom_range(0, 7));
            cdb_data     = $urandom;
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_reservation_station.md
ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
Parameters:
REQ-001 SHALL provide parameter RS_DEPTH, default 4, meaning the number of reservation entries (2..8).
REQ-002 SHALL size tag ports by `ROB_ENTRY_WIDTH (W) from defines.vh and opcodes by the codebase ALU opcode encoding (4 bits, 0 = NOP).

Ports:
REQ-003 SHALL have: clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have: flush  in  1  ROB misprediction flush; discards all entries and pending issue.
REQ-006 SHALL have: disp_valid  in  1  dispatch request.
REQ-007 SHALL have: disp_op  in  4  ALU opcode.
REQ-008 SHALL have: disp_vj, disp_vk  in  32 each  operand values, valid when the matching tag is not pending.
REQ-009 SHALL have: disp_qj, disp_qk  in  W each  producer ROB tags.
REQ-010 SHALL have: disp_qj_pend, disp_qk_pend  in  1 each  operand awaits producer tag.
REQ-011 SHALL have: disp_dest  in  W  destination ROB tag.
REQ-012 SHALL have: rs_full  out  1  no free entry (combinational from state).
REQ-013 SHALL have: rs_count  out  4  occupied entries.
REQ-014 SHALL have: cdb_valid  in  1, cdb_tag  in  W, cdb_data  in  32  common data bus broadcast.
REQ-015 SHALL have: ALUOp  out  4, ALUSrcA  out  32, ALUSrcB  out  32, Dest  out  W  registered issue port driving the ALU.

Function
REQ-016 SHALL accept a dispatch at a rising edge when disp_valid=1, rs_full=0, disp_op!=0 and flush=0; otherwise the dispatch SHALL be dropped with no state change.
REQ-017 SHALL write an accepted dispatch into the lowest-index free entry.
REQ-018 SHALL, on any edge with cdb_valid=1, capture cdb_data as Vj (Vk) and clear the pending flag in every occupied entry whose pending qj (qk) equals cdb_tag.
REQ-019 SHALL apply the same CDB match to the operands of a dispatch accepted on that edge, so a same-edge broadcast is never missed.
REQ-020 SHALL treat an entry as ready when both operands are not pending, using state held before the edge; a CDB wake-up makes an entry issuable on the following edge, never the same one.
REQ-021 SHALL issue at most one ready entry per edge, selecting the lowest-index ready entry.
REQ-022 SHALL register the issued entry's op, Vj, Vk and dest onto ALUOp/ALUSrcA/ALUSrcB/Dest, and free that entry, on the same edge.
REQ-023 SHALL drive ALUOp=0, ALUSrcA=0, ALUSrcB=0, Dest=0 after any edge with no issue, so the ALU sees NOP (busy=0).
REQ-024 SHALL give a minimum latency of one edge: an entry dispatched ready at edge E appears on the issue port after edge E+1.
REQ-025 SHALL not reuse a slot freed by issue until the following edge; rs_full reflects occupancy before the edge.
REQ-026 SHALL keep rs_count equal to the number of occupied entries: +1 on accept, -1 on issue, unchanged when both occur.
REQ-027 SHALL, on flush=1 at an edge, clear all entries and the issue registers; flush overrides dispatch, CDB capture and issue.
REQ-028 SHALL hold a pending operand value unused (don't care) until captured.

Reset
REQ-029 SHALL, on rst=1 regardless of clk, immediately clear all entry valid/pending flags and drive ALUOp=0, ALUSrcA=0, ALUSrcB=0, Dest=0, rs_count=0, rs_full=0.
REQ-030 SHALL ignore dispatch and CDB while rst=1, including reset asserted mid-operation; the first accept is possible on the first edge after deassertion.

Verification
REQ-031 Ready dispatch: op=ADD, vj=5, vk=7, no pend, dest=3 at edge E -> after E+1: ALUOp=ADD, SrcA=5, SrcB=7, Dest=3; after E+2: ALUOp=0.
REQ-032 Wake-up: dispatch SUB with qj=2 pend, vk=1; cdb tag=2 data=0x10 two edges later -> issue one edge after the broadcast with SrcA=0x10, SrcB=1.
REQ-033 Same-edge bypass: dispatch with qk=6 pend while cdb_valid, tag=6, data=0xAB -> entry issues next edge with SrcB=0xAB.
REQ-034 Full/priority: fill 4 entries, entries 1 and 3 ready -> rs_full=1, 5th dispatch dropped, entry 1 issues before 3, rs_count 4->3->2.
REQ-035 Flush: 3 occupied entries plus a valid dispatch and CDB hit on the same edge with flush=1 -> rs_count=0, ALUOp=0, nothing issues afterwards.
REQ-036 Async reset: assert rst between edges with entries valid -> outputs zero before the next edge; no issue after deassertion.
